fifo_stream_reader: RTL and testbench

//  Read-side master for the synchronous FIFO. Drains the FIFO through its
//  rd_en/data_out/empty port and hands the words to a downstream valid/ready

---
 rtl/fifo_stream_reader.sv | 76 +++++++
 tb/tb_fifo_stream_reader.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: drains it into a valid/ready
// stream through a 3-entry skid buffer that absorbs the FIFO read latency.
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  underflow_err,
  output logic                  idle
);

  localparam int BUF_DEPTH = 3;

  logic [FIFO_WIDTH-1:0] mem [BUF_DEPTH];
  logic [1:0]            head;
  logic [1:0]            tail;
  logic [1:0]            buf_cnt;
  logic                  inflight;
  logic                  push;
  logic                  pop;
  logic [2:0]            credit;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // In-flight word already owns a slot, so m_ready never reaches rd_en.
  assign credit     = {1'b0, buf_cnt} + {2'b00, inflight};
  assign fifo_rd_en = rst_n & enable & ~fifo_empty
                    & (credit < 3'(BUF_DEPTH));

  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = mem[head];
  assign push    = inflight;
  assign pop     = m_valid & m_ready;
  assign idle    = ~rst_n | (~m_valid & ~inflight & fifo_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++)
        mem[i] <= '0;
      head          <= 2'd0;
      tail          <= 2'd0;
      buf_cnt       <= 2'd0;
      inflight      <= 1'b0;
      rd_count      <= '0;
      underflow_err <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (push) begin
        mem[tail] <= fifo_data_out;
        tail      <= ptr_inc(tail);
        rd_count  <= rd_count + CNT_WIDTH'(1);
      end
      if (pop)
        head <= ptr_inc(head);
      if (push && !pop)
        buf_cnt <= buf_cnt + 2'd1;
      else if (pop && !push)
        buf_cnt <= buf_cnt - 2'd1;
      if (fifo_underflow)
        underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO model
// feeding it and a monitor recording every accepted stream word.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] fifo_data_out;
  logic        fifo_empty;
  logic        fifo_underflow;
  logic        fifo_rd_en;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  rd_count;
  logic        underflow_err;
  logic        idle;

  int total = 0;
  int bad   = 0;

  logic [15:0] fmem [256];
  int          wp = 0;
  int          rp = 0;
  logic        flush = 1'b0;
  int          cyc = 0;
  int          rden_cnt = 0;
  logic [15:0] rx [$];
  int          rx_cyc [$];

  always #5 clk = ~clk;

  fifo_stream_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .rd_count(rd_count), .underflow_err(underflow_err), .idle(idle)
  );

  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      rden_cnt      <= rden_cnt + 1;
      fifo_data_out <= fmem[rp % 256];
      rp            <= rp + 1;
    end else if (flush) begin
      rp <= wp;
    end
    if (m_valid && m_ready) begin
      rx.push_back(m_data);
      rx_cyc.push_back(cyc);
    end
  end

  task automatic fifo_push(input logic [15:0] v);
    fmem[wp % 256] = v;
    wp = wp + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b0;
    m_ready = 1'b0;
    fifo_underflow = 1'b0;
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_rx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rx.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    m_ready = 1'b0;
    fifo_underflow = 1'b0;
    fifo_push(16'h5555);
    #1;
    total++;
    if (fifo_rd_en !== 1'b0) begin
      bad++; $display("FAIL reset_rd_en got=%b want=0", fifo_rd_en);
    end
    total++;
    if (idle !== 1'b1) begin
      bad++; $display("FAIL reset_idle got=%b want=1", idle);
    end
    total++;
    if (m_valid !== 1'b0 || m_data !== 16'h0) begin
      bad++; $display("FAIL reset_stream got=%b/%h want=0/0000", m_valid, m_data);
    end
    total++;
    if (rd_count !== 4'd0 || underflow_err !== 1'b0) begin
      bad++; $display("FAIL reset_cnt_err got=%0d/%b want=0/0", rd_count, underflow_err);
    end
  endtask

  task automatic test_stream();
    int b;
    int r0;
    bit ok;
    do_reset();
    b = rx.size();
    r0 = rden_cnt;
    for (int i = 1; i <= 8; i++) fifo_push(16'(i));
    m_ready = 1'b1;
    enable = 1'b1;
    #1;
    total++;
    if (fifo_rd_en !== 1'b1) begin
      bad++; $display("FAIL t1_first_rd_en got=%b want=1", fifo_rd_en);
    end
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0) begin
      bad++; $display("FAIL t1_valid_n1 got=%b want=0", m_valid);
    end
    @(negedge clk);
    total++;
    if (m_valid !== 1'b1 || m_data !== 16'h0001) begin
      bad++; $display("FAIL t1_valid_n2 got=%b/%h want=1/0001", m_valid, m_data);
    end
    wait_rx(b + 8, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL t1_timeout got=%0d want=8", rx.size() - b);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (rx[b+i] !== 16'(i + 1)) begin
          bad++; $display("FAIL t1_data[%0d] got=%h want=%h", i, rx[b+i], 16'(i + 1));
        end
      end
      total++;
      if (rx_cyc[b+7] - rx_cyc[b] != 7) begin
        bad++; $display("FAIL t1_b2b got=%0d want=7", rx_cyc[b+7] - rx_cyc[b]);
      end
    end
    repeat (2) @(negedge clk);
    total++;
    if (rden_cnt - r0 != 8) begin
      bad++; $display("FAIL t1_rd_pulses got=%0d want=8", rden_cnt - r0);
    end
    total++;
    if (rd_count !== 4'd8) begin
      bad++; $display("FAIL t1_rd_count got=%0d want=8", rd_count);
    end
    total++;
    if (idle !== 1'b1) begin
      bad++; $display("FAIL t1_idle got=%b want=1", idle);
    end
  endtask

  task automatic test_backpressure();
    int b;
    int r0;
    bit ok;
    do_reset();
    b = rx.size();
    r0 = rden_cnt;
    for (int i = 1; i <= 8; i++) fifo_push(16'(i));
    enable = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (rden_cnt - r0 != 3 || fifo_rd_en !== 1'b0) begin
      bad++; $display("FAIL t2_credit got=%0d/%b want=3/0", rden_cnt - r0, fifo_rd_en);
    end
    total++;
    if (m_valid !== 1'b1 || m_data !== 16'h0001) begin
      bad++; $display("FAIL t2_hold got=%b/%h want=1/0001", m_valid, m_data);
    end
    m_ready = 1'b1;
    wait_rx(b + 8, ok);
    repeat (3) @(negedge clk);
    total++;
    if (!ok || rx.size() - b != 8) begin
      bad++; $display("FAIL t2_count got=%0d want=8", rx.size() - b);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (rx[b+i] !== 16'(i + 1)) begin
          bad++; $display("FAIL t2_data[%0d] got=%h want=%h", i, rx[b+i], 16'(i + 1));
        end
      end
    end
  endtask

  task automatic test_toggle_ready();
    int b;
    bit ok;
    do_reset();
    b = rx.size();
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fifo_push(16'h0100 + 16'(i));
      m_ready = ~m_ready;
      @(negedge clk);
    end
    m_ready = 1'b1;
    wait_rx(b + 20, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL t3_timeout got=%0d want=20", rx.size() - b);
    end else begin
      for (int i = 0; i < 20; i++) begin
        total++;
        if (rx[b+i] !== 16'h0100 + 16'(i)) begin
          bad++; $display("FAIL t3_data[%0d] got=%h want=%h", i, rx[b+i], 16'h0100 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_enable_gate();
    int b;
    int r0;
    bit ok;
    do_reset();
    b = rx.size();
    r0 = rden_cnt;
    for (int i = 0; i < 8; i++) fifo_push(16'h0040 + 16'(i));
    m_ready = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (rden_cnt - r0 != 3 || rx.size() - b != 3) begin
      bad++; $display("FAIL t4_paused got=%0d/%0d want=3/3", rden_cnt - r0, rx.size() - b);
    end
    total++;
    if (idle !== 1'b0) begin
      bad++; $display("FAIL t4_idle got=%b want=0", idle);
    end
    enable = 1'b1;
    wait_rx(b + 8, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL t4_timeout got=%0d want=8", rx.size() - b);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (rx[b+i] !== 16'h0040 + 16'(i)) begin
          bad++; $display("FAIL t4_data[%0d] got=%h want=%h", i, rx[b+i], 16'h0040 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_underflow_wrap();
    int b;
    bit ok;
    do_reset();
    b = rx.size();
    fifo_underflow = 1'b1;
    @(negedge clk);
    fifo_underflow = 1'b0;
    total++;
    if (underflow_err !== 1'b1) begin
      bad++; $display("FAIL t5_err_set got=%b want=1", underflow_err);
    end
    for (int i = 0; i < 17; i++) fifo_push(16'h0200 + 16'(i));
    m_ready = 1'b1;
    enable = 1'b1;
    wait_rx(b + 17, ok);
    repeat (2) @(negedge clk);
    total++;
    if (!ok || rd_count !== 4'd1) begin
      bad++; $display("FAIL t5_wrap got=%0d want=1", rd_count);
    end
    total++;
    if (underflow_err !== 1'b1) begin
      bad++; $display("FAIL t5_err_sticky got=%b want=1", underflow_err);
    end
    do_reset();
    total++;
    if (underflow_err !== 1'b0) begin
      bad++; $display("FAIL t5_err_clr got=%b want=0", underflow_err);
    end
  endtask

  task automatic test_mid_reset();
    int b;
    bit ok;
    do_reset();
    for (int i = 1; i <= 8; i++) fifo_push(16'(i));
    enable = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (m_valid !== 1'b1 || rd_count !== 4'd2) begin
      bad++; $display("FAIL t6_pre got=%b/%0d want=1/2", m_valid, rd_count);
    end
    rst_n = 1'b0;
    enable = 1'b0;
    flush = 1'b1;
    #1;
    total++;
    if (m_valid !== 1'b0 || rd_count !== 4'd0) begin
      bad++; $display("FAIL t6_async got=%b/%0d want=0/0", m_valid, rd_count);
    end
    @(negedge clk);
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) fifo_push(16'hA000 + 16'(i));
    b = rx.size();
    rst_n = 1'b1;
    m_ready = 1'b1;
    enable = 1'b1;
    wait_rx(b + 4, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL t6_timeout got=%0d want=4", rx.size() - b);
    end else begin
      total++;
      if (rx[b] !== 16'hA000) begin
        bad++; $display("FAIL t6_first got=%h want=a000", rx[b]);
      end
      total++;
      if (rx[b+3] !== 16'hA003) begin
        bad++; $display("FAIL t6_last got=%h want=a003", rx[b+3]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle_ready();
    test_enable_gate();
    test_underflow_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
